// File: rtl/m_mc_ctrl.sv
// Multi-cycle IF/ID/EX/WB sequencer for the single-register RISC-V datapath.
// Define MC_PERF_EN to build the stall-cycle counter on r_stall_cnt.
module m_mc_ctrl #(
  parameter int CNT_W  = 32,
  parameter int TO_CYC = 16
) (
  input  logic             w_clk,
  input  logic             w_rst_n,
  input  logic             w_start,
  input  logic             w_stall,
  input  logic             w_imem_ack,
  input  logic [31:0]      w_ir,
  output logic             w_imem_req,
  output logic             w_ir_we,
  output logic             w_pc_we,
  output logic             w_rf_we,
  output logic [2:0]       w_state,
  output logic             r_halted,
  output logic             r_err,
  output logic [CNT_W-1:0] r_icnt,
  output logic [CNT_W-1:0] r_stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

  state_e           state_q;
  logic [31:0]      ir_q;
  logic [7:0]       to_q;
  logic             halted_q, err_q;
  logic [CNT_W-1:0] icnt_q;
  logic             is_sys, rd_wr, in_core;

  assign is_sys  = (ir_q == 32'h0000_0073) || (ir_q == 32'h0010_0073);
  assign rd_wr   = ((ir_q[6:0] == 7'b0110011) || (ir_q[6:0] == 7'b0010011)) &&
                   (ir_q[11:7] != 5'd0);
  assign in_core = (state_q == S_ID) || (state_q == S_EX) || (state_q == S_WB);

  // Strobes are decoded straight from the registered state so the datapath
  // sees them in the same cycle the state is presented.
  always_comb begin
    w_imem_req = (state_q == S_IF);
    w_ir_we    = (state_q == S_IF) && w_imem_ack;
    w_pc_we    = (state_q == S_WB) && !w_stall;
    w_rf_we    = (state_q == S_WB) && !w_stall && rd_wr;
  end

  assign w_state  = state_q;
  assign r_halted = halted_q;
  assign r_err    = err_q;
  assign r_icnt   = icnt_q;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      to_q     <= '0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      icnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (w_start) state_q <= S_IF;
        S_IF: begin
          // A late ack takes priority over the timeout on the same cycle.
          if (w_imem_ack) begin
            ir_q    <= w_ir;
            to_q    <= '0;
            state_q <= S_ID;
          end else if (to_q == TO_LAST) begin
            to_q     <= '0;
            err_q    <= 1'b1;
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            to_q <= to_q + 8'd1;
          end
        end
        S_ID: if (!w_stall) begin
          if (is_sys) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            state_q <= S_EX;
          end
        end
        S_EX: if (!w_stall) state_q <= S_WB;
        S_WB: if (!w_stall) begin
          icnt_q  <= icnt_q + 1'b1;
          state_q <= S_IF;
        end
        S_HALT: if (w_start) begin
          halted_q <= 1'b0;
          err_q    <= 1'b0;
          state_q  <= S_IF;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MC_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n)               stall_cnt_q <= '0;
    else if (in_core && w_stall) stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign r_stall_cnt = stall_cnt_q;
`else
  assign r_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_m_mc_ctrl.sv
// Directed + randomized bench for m_mc_ctrl; expectations come from a
// per-instruction phase model (IF waits, stalls, WB retire) kept here.
module tb_m_mc_ctrl;

  logic        w_clk, w_rst_n, w_start, w_stall, w_imem_ack;
  logic [31:0] w_ir;
  logic        w_imem_req, w_ir_we, w_pc_we, w_rf_we;
  logic [2:0]  w_state;
  logic        r_halted, r_err;
  logic [31:0] r_icnt, r_stall_cnt;

  m_mc_ctrl #(.CNT_W(32), .TO_CYC(16)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .w_start(w_start), .w_stall(w_stall),
    .w_imem_ack(w_imem_ack), .w_ir(w_ir), .w_imem_req(w_imem_req),
    .w_ir_we(w_ir_we), .w_pc_we(w_pc_we), .w_rf_we(w_rf_we), .w_state(w_state),
    .r_halted(r_halted), .r_err(r_err), .r_icnt(r_icnt), .r_stall_cnt(r_stall_cnt)
  );

`ifdef MC_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  int          n_tot = 0, n_pass = 0;
  logic [31:0] exp_icnt, exp_stall;
  bit          exp_halted, exp_err;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tot++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic chk_all(input string tag, input int st, input bit req,
                         input bit irwe, input bit pcwe, input bit rfwe);
    ck({tag, ".state"},  {29'd0, w_state}, st);
    ck({tag, ".req"},    {31'd0, w_imem_req}, {31'd0, req});
    ck({tag, ".ir_we"},  {31'd0, w_ir_we}, {31'd0, irwe});
    ck({tag, ".pc_we"},  {31'd0, w_pc_we}, {31'd0, pcwe});
    ck({tag, ".rf_we"},  {31'd0, w_rf_we}, {31'd0, rfwe});
    ck({tag, ".halted"}, {31'd0, r_halted}, {31'd0, exp_halted});
    ck({tag, ".err"},    {31'd0, r_err}, {31'd0, exp_err});
    ck({tag, ".icnt"},   r_icnt, exp_icnt);
    ck({tag, ".stcnt"},  r_stall_cnt, PERF ? exp_stall : 32'd0);
  endtask

  // Each cycle: inputs driven 1 after the edge, outputs checked 2 after.
  task automatic cyc();
    @(posedge w_clk); #1;
  endtask
  task automatic settle();
    #1;
  endtask

  function automatic bit writes_rd(input logic [31:0] ir);
    return ((ir[6:0] == 7'b0110011) || (ir[6:0] == 7'b0010011)) && (ir[11:7] != 5'd0);
  endfunction

  function automatic logic [31:0] rnd_ir(input bit allow_halt);
    logic [31:0] v;
    int p;
    v = $urandom;
    p = $urandom_range(0, 9);
    v[11:7] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    case (p)
      0, 1, 2: v[6:0] = 7'b0110011;
      3, 4, 5: v[6:0] = 7'b0010011;
      6:       v[6:0] = 7'b0000011;
      7:       v[6:0] = 7'b1100011;
      8:       if (allow_halt) v = 32'h0000_0073; else v[6:0] = 7'b0110111;
      default: if (allow_halt) v = 32'h0010_0073; else v[6:0] = 7'b0110111;
    endcase
    return v;
  endfunction

  // Starts in the first IF cycle; ends in the first cycle after WB (IF) or in HALT.
  task automatic do_instr(input string tag, input logic [31:0] ir_v, input int wait_n,
                          input int s_id, input int s_ex, input int s_wb);
    bit halt;
    halt = (ir_v == 32'h0000_0073) || (ir_v == 32'h0010_0073);
    for (int k = 0; k <= wait_n; k++) begin
      w_start = 1'b0;
      w_imem_ack = (k == wait_n);
      w_ir = w_imem_ack ? ir_v : $urandom;
      w_stall = 1'($urandom_range(0, 1));
      settle(); chk_all({tag, ".if"}, 1, 1, w_imem_ack, 0, 0); cyc();
    end
    w_imem_ack = 1'b0;
    for (int k = 0; k < s_id; k++) begin
      w_stall = 1'b1; w_ir = $urandom;
      settle(); chk_all({tag, ".id_st"}, 2, 0, 0, 0, 0); exp_stall++; cyc();
    end
    w_stall = 1'b0;
    settle(); chk_all({tag, ".id"}, 2, 0, 0, 0, 0);
    if (halt) begin
      exp_halted = 1'b1;
      cyc();
      return;
    end
    cyc();
    for (int k = 0; k < s_ex; k++) begin
      w_stall = 1'b1;
      settle(); chk_all({tag, ".ex_st"}, 3, 0, 0, 0, 0); exp_stall++; cyc();
    end
    w_stall = 1'b0;
    settle(); chk_all({tag, ".ex"}, 3, 0, 0, 0, 0); cyc();
    for (int k = 0; k < s_wb; k++) begin
      w_stall = 1'b1;
      settle(); chk_all({tag, ".wb_st"}, 4, 0, 0, 0, 0); exp_stall++; cyc();
    end
    w_stall = 1'b0;
    settle(); chk_all({tag, ".wb"}, 4, 0, 0, 1, writes_rd(ir_v)); exp_icnt++; cyc();
  endtask

  task automatic hold_halt(input int n);
    for (int k = 0; k < n; k++) begin
      w_start = 1'b0; w_stall = 1'($urandom_range(0, 1)); w_imem_ack = 1'($urandom_range(0, 1));
      settle(); chk_all("halt", 5, 0, 0, 0, 0); cyc();
    end
  endtask

  task automatic restart();
    w_start = 1'b1; w_stall = 1'b0; w_imem_ack = 1'b0;
    settle(); chk_all("halt_go", 5, 0, 0, 0, 0); cyc();
    w_start = 1'b0; exp_halted = 1'b0; exp_err = 1'b0;
  endtask

  task automatic timeout_noack();
    for (int k = 0; k < 16; k++) begin
      w_imem_ack = 1'b0; w_stall = 1'($urandom_range(0, 1)); w_ir = $urandom;
      settle(); chk_all("to", 1, 1, 0, 0, 0); cyc();
    end
    exp_err = 1'b1; exp_halted = 1'b1;
  endtask

  task automatic start_from_idle();
    w_start = 1'b1;
    settle(); chk_all("idle_go", 0, 0, 0, 0, 0); cyc();
    w_start = 1'b0;
  endtask

  task automatic model_reset();
    exp_icnt = '0; exp_stall = '0; exp_halted = 1'b0; exp_err = 1'b0;
  endtask

  initial begin
    w_rst_n = 1'b1; w_start = 1'b0; w_stall = 1'b0; w_imem_ack = 1'b0; w_ir = '0;
    model_reset();
    #1 w_rst_n = 1'b0;
    #2 chk_all("reset", 0, 0, 0, 0, 0);
    cyc(); cyc();
    w_rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle(); chk_all("idle", 0, 0, 0, 0, 0); cyc();
    end
    start_from_idle();

    do_instr("addi", 32'h0010_8093, 0, 0, 0, 0);
    ck("icnt_first", r_icnt, 32'd1);
    do_instr("add_x0", 32'h0010_0033, 3, 0, 0, 0);
    do_instr("ecall", 32'h0000_0073, 0, 0, 0, 0);
    hold_halt(2);
    restart();
    ck("icnt_kept", r_icnt, 32'd2);
    do_instr("stall_ex", 32'h0010_8093, 0, 0, 5, 0);
    ck("stall5", r_stall_cnt, PERF ? 32'd5 : 32'd0);

    timeout_noack();
    hold_halt(1);
    restart();
    do_instr("to_ack16", 32'h0010_8093, 15, 0, 0, 0);
    ck("to_ack16_err", {31'd0, r_err}, 32'd0);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        timeout_noack();
        hold_halt($urandom_range(0, 2));
        restart();
      end
      do_instr("rnd", rnd_ir(1'b1), $urandom_range(0, 4),
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
               ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
      if (exp_halted) begin
        hold_halt($urandom_range(0, 2));
        restart();
      end
    end

    // Fresh run to exactly seven retired, then async reset mid-EX.
    w_rst_n = 1'b0; model_reset();
    settle(); chk_all("rst2", 0, 0, 0, 0, 0); cyc();
    w_rst_n = 1'b1;
    start_from_idle();
    for (int n = 0; n < 7; n++) do_instr("pre", rnd_ir(1'b0), $urandom_range(0, 2), 0, 0, 0);
    w_imem_ack = 1'b1; w_ir = 32'h0010_8093;
    settle(); chk_all("m_if", 1, 1, 1, 0, 0); cyc();
    w_imem_ack = 1'b0;
    settle(); chk_all("m_id", 2, 0, 0, 0, 0); cyc();
    settle(); chk_all("m_ex", 3, 0, 0, 0, 0);
    ck("icnt7", r_icnt, 32'd7);
    #1 w_rst_n = 1'b0;
    model_reset();
    #1 chk_all("async_rst", 0, 0, 0, 0, 0);
    cyc();
    settle(); chk_all("rst_hold", 0, 0, 0, 0, 0);
    w_rst_n = 1'b1;
    cyc();
    start_from_idle();
    do_instr("post", 32'h0010_8093, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
